// File: rtl/cpu_pkg.sv
// Shared types and constants for the 11-bit accumulator CPU control path.
package cpu_pkg;

  localparam int DATA_W = 11;
  localparam int OPC_W  = 5;

  typedef enum logic [OPC_W-1:0] {
    OP_HLT  = 5'b00000,
    OP_STO  = 5'b00001,
    OP_LD   = 5'b00010,
    OP_LDI  = 5'b00011,
    OP_ADD  = 5'b00100,
    OP_ADDI = 5'b00101,
    OP_SUB  = 5'b00110,
    OP_SUBI = 5'b00111,
    OP_BEQ  = 5'b01000,
    OP_BNE  = 5'b01001,
    OP_BGT  = 5'b01010,
    OP_BGE  = 5'b01011,
    OP_BLT  = 5'b01100,
    OP_BLE  = 5'b01101,
    OP_JMP  = 5'b01110
  } opcode_t;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    MEM_RD,
    LOAD_WB,
    ALU_WB,
    STORE,
    BRANCH,
    HALT
  } state_t;

  localparam logic [1:0] SEL_A_MEM = 2'b00;
  localparam logic [1:0] SEL_A_EXT = 2'b01;
  localparam logic [1:0] SEL_A_ALU = 2'b10;
  localparam logic       SEL_B_EXT = 1'b0;
  localparam logic       SEL_B_MEM = 1'b1;
  localparam logic       ALU_ADD   = 1'b0;
  localparam logic       ALU_SUB   = 1'b1;

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluation from opcode and accumulator flags.
// Non-branch opcodes always evaluate as not taken.
module branch_cond
  import cpu_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  input  logic             z,
  input  logic             n,
  output logic             taken
);

  // Condition table: one flag expression per branch flavour.
  always_comb begin
    taken = 1'b0;
    case (opcode)
      OP_BEQ:  taken = z;
      OP_BNE:  taken = ~z;
      OP_BGT:  taken = ~z & ~n;
      OP_BGE:  taken = ~n;
      OP_BLT:  taken = n;
      OP_BLE:  taken = n | z;
      OP_JMP:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit for the accumulator CPU.
//
// state   | meaning
// --------+-------------------------------------------------
// FETCH   | load IR
// DECODE  | PC+1, latch opcode and branch condition, dispatch
// MEM_RD  | data-memory read for LD/ADD/SUB
// LOAD_WB | accumulator load from memory (LD) or immediate (LDI)
// ALU_WB  | accumulator load from ALU result
// STORE   | write accumulator to data memory
// BRANCH  | overwrite PC with target when condition held
// HALT    | sticky stop, left only through reset
module control_unit
  import cpu_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [OPC_W-1:0] opcode_in,
  input  logic             z_in,
  input  logic             n_in,
  output logic             ir_en,
  output logic             pc_en,
  output logic             sel_pc,
  output logic             rd_data_mem,
  output logic             wr_data_mem,
  output logic [1:0]       sel_A,
  output logic             sel_B,
  output logic             alu_op,
  output logic             wr_acc,
  output logic             halted_out,
  output logic             illegal_out
);

  state_t           state_q, state_d;
  logic [OPC_W-1:0] op_q;
  logic             taken_q;
  logic             taken_d;

  branch_cond u_branch_cond (
    .opcode (opcode_in),
    .z      (z_in),
    .n      (n_in),
    .taken  (taken_d)
  );

  // State register; opcode and branch condition are captured once, in DECODE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FETCH;
      op_q    <= '0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) begin
        op_q    <= opcode_in;
        taken_q <= taken_d;
      end
    end
  end

  // Next-state and Moore output decode; reset gates every output so no write
  // can leak out of a cycle that is being reset.
  always_comb begin
    state_d     = state_q;
    ir_en       = 1'b0;
    pc_en       = 1'b0;
    sel_pc      = 1'b0;
    rd_data_mem = 1'b0;
    wr_data_mem = 1'b0;
    sel_A       = SEL_A_MEM;
    sel_B       = SEL_B_EXT;
    alu_op      = ALU_ADD;
    wr_acc      = 1'b0;
    halted_out  = 1'b0;
    illegal_out = 1'b0;
    case (state_q)
      FETCH: begin
        ir_en   = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        pc_en = 1'b1;
        case (opcode_in)
          OP_LD, OP_ADD, OP_SUB:  state_d = MEM_RD;
          OP_LDI:                 state_d = LOAD_WB;
          OP_ADDI, OP_SUBI:       state_d = ALU_WB;
          OP_STO:                 state_d = STORE;
          OP_BEQ, OP_BNE, OP_BGT, OP_BGE,
          OP_BLT, OP_BLE, OP_JMP: state_d = BRANCH;
          OP_HLT:                 state_d = HALT;
          default: begin
            illegal_out = 1'b1;
            state_d     = FETCH;
          end
        endcase
      end
      MEM_RD: begin
        rd_data_mem = 1'b1;
        state_d     = (op_q == OP_LD) ? LOAD_WB : ALU_WB;
      end
      LOAD_WB: begin
        wr_acc  = 1'b1;
        sel_A   = (op_q == OP_LD) ? SEL_A_MEM : SEL_A_EXT;
        state_d = FETCH;
      end
      ALU_WB: begin
        wr_acc  = 1'b1;
        sel_A   = SEL_A_ALU;
        sel_B   = (op_q == OP_ADD || op_q == OP_SUB) ? SEL_B_MEM : SEL_B_EXT;
        alu_op  = (op_q == OP_SUB || op_q == OP_SUBI) ? ALU_SUB : ALU_ADD;
        state_d = FETCH;
      end
      STORE: begin
        wr_data_mem = 1'b1;
        state_d     = FETCH;
      end
      BRANCH: begin
        sel_pc  = 1'b1;
        pc_en   = taken_q;
        state_d = FETCH;
      end
      HALT: begin
        halted_out = 1'b1;
        state_d    = HALT;
      end
      default: state_d = FETCH;
    endcase
    if (reset) begin
      ir_en       = 1'b0;
      pc_en       = 1'b0;
      sel_pc      = 1'b0;
      rd_data_mem = 1'b0;
      wr_data_mem = 1'b0;
      sel_A       = SEL_A_MEM;
      sel_B       = SEL_B_EXT;
      alu_op      = ALU_ADD;
      wr_acc      = 1'b0;
      halted_out  = 1'b0;
      illegal_out = 1'b0;
    end
  end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle control unit for the 11-bit accumulator CPU. Decodes the 5-bit opcode from the instruction register and sequences the datapath: PC update, IR load, data-memory read/write, accumulator source select (`sel_A`), ALU operand-B select (`sel_B`, driving `mux_B`), ALU operation and accumulator write. It sits between the instruction register, the flag register, and every datapath enable/select.

## Interface
- No parameters. Widths are fixed by the shared package: opcode 5 bits, data 11 bits.
- `clock` in 1 — single clock, all state on rising edge.
- `reset` in 1 — synchronous, active-high.
- `opcode_in` in 5 — IR[15:11]; stable from the end of FETCH until the next FETCH.
- `z_in` in 1 — accumulator zero flag.
- `n_in` in 1 — accumulator negative flag.
- `ir_en` out 1 — load IR.
- `pc_en` out 1 — load PC.
- `sel_pc` out 1 — PC source: 0 = PC+1, 1 = IR operand (branch target).
- `rd_data_mem` out 1 — data-memory read strobe.
- `wr_data_mem` out 1 — data-memory write strobe (stores ACC).
- `sel_A` out 2 — ACC source: 00 = data memory, 01 = ext (immediate), 10 = ALU result.
- `sel_B` out 1 — ALU operand B: 0 = `ext_in`, 1 = `data_memory_in`.
- `alu_op` out 1 — 0 = add, 1 = subtract.
- `wr_acc` out 1 — accumulator write enable.
- `halted_out` out 1 — high while in HALT.
- `illegal_out` out 1 — one-cycle pulse on an undefined opcode.

## Operation
- Opcodes: HLT 00000, STO 00001, LD 00010, LDI 00011, ADD 00100, ADDI 00101, SUB 00110, SUBI 00111, BEQ 01000, BNE 01001, BGT 01010, BGE 01011, BLT 01100, BLE 01101, JMP 01110. All others are illegal.
- States: FETCH, DECODE, MEM_RD, LOAD_WB, ALU_WB, STORE, BRANCH, HALT.
- **FETCH:** `ir_en`=1. Next state is DECODE.
- **DECODE:** `pc_en`=1, `sel_pc`=0. Latch `opcode_in` into `op_q`. Latch the branch condition into `taken_q`. Next state:
  - LD, ADD, SUB go to MEM_RD.
  - LDI goes to LOAD_WB.
  - ADDI, SUBI go to ALU_WB.
  - STO goes to STORE.
  - Branch and JMP go to BRANCH.
  - HLT goes to HALT.
  - An illegal opcode pulses `illegal_out` and goes to FETCH with no other side effect.
- **MEM_RD:** `rd_data_mem`=1. LD goes to LOAD_WB; ADD and SUB go to ALU_WB.
- **LOAD_WB:** `wr_acc`=1. `sel_A`=00 for LD, 01 for LDI. Next state is FETCH.
- **ALU_WB:** `wr_acc`=1, `sel_A`=10. `sel_B`=1 for ADD/SUB, 0 for ADDI/SUBI. `alu_op`=1 for SUB/SUBI. Next state is FETCH.
- **STORE:** `wr_data_mem`=1. Next state is FETCH.
- **BRANCH:** `sel_pc`=1, `pc_en`=`taken_q`. Next state is FETCH.
- **HALT:** `halted_out`=1 and all strobes are 0. The state is sticky; only `reset` exits it.
- Branch conditions:
  - BEQ: z
  - BNE: !z
  - BGT: !z & !n
  - BGE: !n
  - BLT: n
  - BLE: n | z
  - JMP: 1
- Outputs are a Moore decode of (state, `op_q`, `taken_q`). There is no combinational path from `opcode_in`, `z_in` or `n_in` to any output, except `illegal_out`, which is decoded in DECODE.
- Outputs not listed for a state are 0. `sel_A`, `sel_B` and `alu_op` read 0 when their write enable is low.

## Timing
- Reset: state = FETCH, `op_q` = 0, `taken_q` = 0. All outputs are forced to 0 during any cycle with `reset`=1, including a reset that arrives mid-instruction. No partial write may occur in the reset cycle. The first FETCH happens the cycle after `reset` deasserts.
- Cycles per instruction:
  - LDI, ADDI, SUBI, STO, branches, JMP: 3.
  - LD, ADD, SUB: 4.
  - Illegal opcode: 2.
  - HLT: 2 to enter HALT.
- The PC increments exactly once per instruction, in DECODE. A taken branch then overwrites the PC in BRANCH; a not-taken branch leaves PC+1.
- Flags are sampled in DECODE. A flag change produced by the previous instruction's ALU_WB or LOAD_WB is already visible, because at least one FETCH cycle separates them.
- Data-memory read data is valid in the cycle after MEM_RD, which is when `sel_A`/`sel_B` select it.

## Structure
- `cpu_pkg` holds:
  - `opcode_t` enum (values above).
  - `state_t` enum.
  - `SEL_A_MEM`/`SEL_A_EXT`/`SEL_A_ALU`, `SEL_B_EXT`/`SEL_B_MEM`, `ALU_ADD`/`ALU_SUB` constants.
  - `DATA_W`=11, `OPC_W`=5.
- One sub-module, `branch_cond`: combinational (opcode, z, n) -> taken. It is reused by any future pipelined control.

## Test plan
- Reset mid-ALU_WB of ADD -> `wr_acc`=0 in the reset cycle; the next cycle is FETCH with `ir_en`=1.
- LDI (00011), then ADDI (00101) -> LDI: `wr_acc` in cycle 3 with `sel_A`=01. ADDI: `wr_acc` in cycle 3 with `sel_A`=10, `sel_B`=0, `alu_op`=0. `pc_en` pulses exactly once per instruction.
- SUB (00110) -> `rd_data_mem` in cycle 3; cycle 4 has `wr_acc`=1, `sel_B`=1, `alu_op`=1, `sel_A`=10. Total 4 cycles.
- BEQ with z=1, then BEQ with z=0 -> first: BRANCH has `pc_en`=1, `sel_pc`=1. Second: BRANCH has `pc_en`=0. Both take 3 cycles.
- BLE with n=0, z=0 gives not taken; BGT with n=0, z=0 gives taken; JMP is always taken.
- Opcode 11111 -> `illegal_out` pulses in DECODE, then FETCH with no writes. HLT -> `halted_out`=1 held 20 cycles with all strobes 0; released only by `reset`.
